ovs_tile_splitter: RTL
======================

// Module: ovs_tile_splitter
// PURPOSE
//  Inverse of the overlap-add stage: buffers one full IMG x IMG frame of words, then re-emits it
//  as NUM_BLOCK_ROOT^2 overlapping SIZE x SIZE tiles (stride SIZE-OVERLAP) for block-wise conv.
//  Sits ahead of the tile conv/FFT engine; its tiles, once processed, return through overlap-add.
//  Single frame buffer: load and emit phases never overlap.
// PARAMETERS
//  NUM_BLOCK_ROOT  4   tiles per row/column (NB); NB*NB tiles per frame
//  SIZE            9   tile edge in words
//  OVERLAP         3   words shared by adjacent tiles; STRIDE = SIZE-OVERLAP (must be >0)
//  DATA_W          64  word width
//  derived: IMG = NB*SIZE-(NB-1)*OVERLAP (27); NPIX = IMG*IMG (729); NTILE = NB*NB (16)
// PORTS
//  clk             in   1        clock
//  reset           in   1        synchronous, active-high
//  in_valid        in   1        input word valid
//  in_ready        out  1        splitter accepts input word
//  in_data         in   DATA_W   frame word, row-major, pixel 0 first
//  out_valid       out  1        tile word valid
//  out_ready       in   1        downstream accepts tile word
//  out_data        out  DATA_W   tile word
//  out_tile_idx    out  clog2(NTILE)  tile number, tr*NB+tc
//  out_row         out  clog2(SIZE)   row within tile
//  out_col         out  clog2(SIZE)   column within tile
//  out_last        out  1        final word of current tile
//  out_frame_last  out  1        final word of final tile
//  frame_done      out  1        one-cycle pulse after last tile word accepted
// BEHAVIOUR
//  - Reset: clk, reset as above. State->LOAD, all counters 0. While reset is high, in_ready=0,
//    out_valid=0, out_data=0, out_tile_idx/row/col=0, out_last/out_frame_last/frame_done=0.
//    Buffer contents are not cleared. Reset mid-LOAD or mid-EMIT aborts the frame; a partial
//    frame is discarded and the next accepted word is pixel 0.
//  - FSM: LOAD -> EMIT after the NPIX-th accepted input word; EMIT -> LOAD after the
//    NPIX-equivalent last tile word (NTILE*SIZE*SIZE = 1296 beats) is accepted.
//  - LOAD: in_ready=1, out_valid=0. Beat on in_valid&in_ready: mem[wr_cnt]<=in_data,
//    wr_cnt++. On beat with wr_cnt==NPIX-1: wr_cnt<=0, state<=EMIT (in_ready=0 next cycle).
//  - EMIT: in_ready=0, out_valid=1 every cycle (no bubbles). out_data = mem[addr] with
//    addr = (tr*STRIDE+r)*IMG + tc*STRIDE + c, from registered counters (r,c,tc,tr).
//  - Beat on out_valid&out_ready advances c; c wraps at SIZE-1 -> r++; r wraps -> tc++;
//    tc wraps at NB-1 -> tr++. out_row=r, out_col=c, out_tile_idx=tr*NB+tc.
//  - out_ready low: all out_* held stable, counters frozen (valid must not drop).
//  - out_last = (r==SIZE-1 && c==SIZE-1); out_frame_last = out_last && tr==NB-1 && tc==NB-1.
//  - On accepted frame-last beat: counters->0, state<=LOAD, frame_done=1 next cycle only;
//    in_ready=1 same next cycle. Throughput 1 word/cycle each phase; zero-cycle turnaround beyond
//    the one-cycle state register update.
//  - in_valid during EMIT is ignored (in_ready=0); no data lost upstream.
//  - Overlapping pixels are emitted once per covering tile (corner pixels up to 4 times).
// TESTING
//  1 Load in_data=pixel index 0..728, out_ready=1 -> 1296 out beats; tile0 (0,0)=0,
//    tile0 (0,8)=8, tile1 (0,0)=6, tile1 (0,8)=14, tile4 (0,0)=162, tile15 (8,8)=728.
//  2 Tile boundaries: out_last high exactly on beats 80,161,...,1295; out_frame_last only on
//    beat 1295; frame_done one cycle after it; in_ready=1 on that same cycle.
//  3 Random out_ready (50%) and random in_valid gaps -> output sequence identical to test 1,
//    out_* stable while out_valid&!out_ready, no beat lost or duplicated.
//  4 in_valid held 1 through EMIT with data 0xDEAD -> ignored; next frame pixel 0 is the
//    first word accepted after frame_done.
//  5 Reset after 300 input words, reload full frame of index+1000 -> tile0 (0,0)=1000,
//    tile15 (8,8)=1728. Reset mid-EMIT (tile 7) -> out_valid=0 next cycle, in_ready=1 after
//    reset released, counters restart at tile 0.
//  6 Two back-to-back frames (values k, then k+2000) -> second frame tiles all offset by 2000.

Source files
------------

// File: rtl/ovs_tile_splitter.sv
// rtl/ovs_tile_splitter.sv - buffers one IMG x IMG frame, re-emits it as NB*NB overlapping SIZE x SIZE tiles
//
// Ports:
//   clk, reset              clock; synchronous active-high reset
//   in_valid/in_ready/in_data
//                           frame words, row-major, pixel 0 first
//   out_valid/out_ready/out_data
//                           tile words, tile-major then row-major within a tile
//   out_tile_idx            tile number tr*NB+tc
//   out_row, out_col        position of the current word within its tile
//   out_last                final word of the current tile
//   out_frame_last          final word of the final tile
//   frame_done              one-cycle pulse after the frame-last word is accepted
module ovs_tile_splitter #(
    parameter int NUM_BLOCK_ROOT = 4,
    parameter int SIZE           = 9,
    parameter int OVERLAP        = 3,
    parameter int DATA_W         = 64,
    localparam int NB            = NUM_BLOCK_ROOT,
    localparam int STRIDE        = SIZE - OVERLAP,
    localparam int IMG           = NB * SIZE - (NB - 1) * OVERLAP,
    localparam int NPIX          = IMG * IMG,
    localparam int NTILE         = NB * NB,
    localparam int TILE_W        = (NTILE > 1) ? $clog2(NTILE) : 1,
    localparam int RC_W          = (SIZE > 1) ? $clog2(SIZE) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [TILE_W-1:0] out_tile_idx,
    output logic [RC_W-1:0]   out_row,
    output logic [RC_W-1:0]   out_col,
    output logic              out_last,
    output logic              out_frame_last,
    output logic              frame_done
);

    localparam int NB_W   = (NB > 1) ? $clog2(NB) : 1;
    localparam int ADDR_W = (NPIX > 1) ? $clog2(NPIX) : 1;

    localparam logic [ADDR_W-1:0] STRIDE_A   = ADDR_W'(STRIDE);
    localparam logic [ADDR_W-1:0] IMG_A      = ADDR_W'(IMG);
    localparam logic [ADDR_W-1:0] LAST_PIX   = ADDR_W'(NPIX - 1);
    localparam logic [RC_W-1:0]   LAST_RC    = RC_W'(SIZE - 1);
    localparam logic [NB_W-1:0]   LAST_T     = NB_W'(NB - 1);

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

    state_t state, state_next;

    logic [DATA_W-1:0] mem [NPIX];

    logic [ADDR_W-1:0] wr_cnt;
    logic [RC_W-1:0]   r, c;
    logic [NB_W-1:0]   tr, tc;
    logic              frame_done_q;

    logic              in_beat, out_beat;
    logic              tile_last_w, frame_last_w;
    logic [ADDR_W-1:0] rd_addr;

    assign tile_last_w  = (r == LAST_RC) && (c == LAST_RC);
    assign frame_last_w = tile_last_w && (tr == LAST_T) && (tc == LAST_T);

    // Tile (tr,tc) has its top-left corner at frame pixel (tr*STRIDE, tc*STRIDE).
    assign rd_addr = (ADDR_W'(tr) * STRIDE_A + ADDR_W'(r)) * IMG_A
                   + ADDR_W'(tc) * STRIDE_A + ADDR_W'(c);

    assign in_beat  = in_valid && in_ready;
    assign out_beat = out_valid && out_ready;

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        if (!reset) begin
            case (state)
                ST_LOAD: begin
                    in_ready = 1'b1;
                    if (in_valid && (wr_cnt == LAST_PIX)) begin
                        state_next = ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    out_valid = 1'b1;
                    if (out_ready && frame_last_w) begin
                        state_next = ST_LOAD;
                    end
                end
                default: state_next = ST_LOAD;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_LOAD;
            wr_cnt       <= '0;
            r            <= '0;
            c            <= '0;
            tr           <= '0;
            tc           <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state        <= state_next;
            frame_done_q <= out_beat && frame_last_w;
            if (in_beat) begin
                wr_cnt <= (wr_cnt == LAST_PIX) ? '0 : wr_cnt + 1'b1;
            end
            if (out_beat) begin
                // Odometer: column, then row, then tile column, then tile row.
                if (c != LAST_RC) begin
                    c <= c + 1'b1;
                end else begin
                    c <= '0;
                    if (r != LAST_RC) begin
                        r <= r + 1'b1;
                    end else begin
                        r <= '0;
                        if (tc != LAST_T) begin
                            tc <= tc + 1'b1;
                        end else begin
                            tc <= '0;
                            tr <= (tr != LAST_T) ? tr + 1'b1 : '0;
                        end
                    end
                end
            end
        end
    end

    // Frame buffer has no reset: contents are always overwritten by a full load before being read.
    always_ff @(posedge clk) begin
        if (in_beat) begin
            mem[wr_cnt] <= in_data;
        end
    end

    assign out_data       = out_valid ? mem[rd_addr] : '0;
    assign out_tile_idx   = reset ? '0 : TILE_W'(tr) * TILE_W'(NB) + TILE_W'(tc);
    assign out_row        = reset ? '0 : r;
    assign out_col        = reset ? '0 : c;
    assign out_last       = out_valid && tile_last_w;
    assign out_frame_last = out_valid && frame_last_w;
    assign frame_done     = frame_done_q && !reset;

endmodule
